// File: rtl/nfa_stream_ctrl.sv
// Stream sequencer for the parallel-NFA PE array: shifts text into a num-slot window,
// fires the PE enables once the window is full and collects match results from the router.
module nfa_stream_ctrl #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned num    = 16,
    parameter int unsigned PE_LAT = 1,
    parameter int unsigned POS_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [num-1:0]        cfg_alu,
    input  logic [num-1:0]        cfg_mask,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DWIDTH-1:0]     in_char,
    input  logic                  in_last,
    output logic [num*DWIDTH-1:0] str_to_router,
    output logic [num-1:0]        ALU_to_router,
    output logic [num-1:0]        en_to_router,
    input  logic [num-1:0]        result_from_router,
    output logic                  match_valid,
    output logic [num-1:0]        match_vec,
    output logic [POS_W-1:0]      match_pos,
    output logic [POS_W-1:0]      match_cnt,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned FILL_W = $clog2(num + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic                          w_accept;
    logic                          w_start;
    logic                          w_done_nxt;
    logic                          w_pipe_busy;
    logic                          w_tag_out;
    logic [POS_W-1:0]              w_tag_pos;
    logic [FILL_W-1:0]             w_fill_nxt;
    logic [POS_W-1:0]              w_char_nxt;
    logic                          w_step_nxt;
    logic                          w_hit;

    logic [num-1:0][DWIDTH-1:0]    r_win;
    logic [num-1:0]                r_alu;
    logic [num-1:0]                r_mask;
    logic [num-1:0]                r_en;
    logic [FILL_W-1:0]             r_fill;
    logic [POS_W-1:0]              r_char;
    logic                          r_step;
    logic [POS_W-1:0]              r_step_pos;
    logic                          r_mvalid;
    logic [num-1:0]                r_mvec;
    logic [POS_W-1:0]              r_mpos;
    logic [POS_W-1:0]              r_mcnt;
    logic                          r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Abort overrides every transition, including a same-cycle start
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_start     = 1'b0;
        w_done_nxt  = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_start     = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        w_accept = 1'b1;
                        if (in_last) w_state_nxt = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!w_pipe_busy) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_fill_nxt = (r_fill >= FILL_W'(num)) ? r_fill : r_fill + FILL_W'(1);
    assign w_char_nxt = (&r_char) ? r_char : r_char + POS_W'(1);
    assign w_step_nxt = w_accept && (w_fill_nxt == FILL_W'(num));
    assign w_hit      = w_tag_out && !abort && (|result_from_router);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win      <= '0;
            r_alu      <= '0;
            r_mask     <= '0;
            r_en       <= '0;
            r_fill     <= '0;
            r_char     <= '0;
            r_step     <= 1'b0;
            r_step_pos <= '0;
            r_mvalid   <= 1'b0;
            r_mvec     <= '0;
            r_mpos     <= '0;
            r_mcnt     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_step   <= w_step_nxt;
            r_en     <= w_step_nxt ? r_mask : '0;
            r_done   <= w_done_nxt;
            r_mvalid <= w_hit;
            if (w_step_nxt) r_step_pos <= w_char_nxt;
            if (cfg_we && (r_state == S_IDLE)) begin
                r_alu  <= cfg_alu;
                r_mask <= cfg_mask;
            end
            if (w_hit) begin
                r_mvec <= result_from_router;
                r_mpos <= w_tag_pos;
                if (!(&r_mcnt)) r_mcnt <= r_mcnt + POS_W'(1);
            end
            if (w_start) begin
                r_win  <= '0;
                r_fill <= '0;
                r_char <= '0;
                r_mcnt <= '0;
            end else if (w_accept) begin
                r_win  <= {in_char, r_win[num-1:1]};
                r_fill <= w_fill_nxt;
                r_char <= w_char_nxt;
            end
        end
    end

    // Valid-tag pipeline that tracks each enable pulse until its result is due
    if (PE_LAT == 0) begin : g_comb
        assign w_tag_out   = r_step;
        assign w_tag_pos   = r_step_pos;
        assign w_pipe_busy = 1'b0;
    end else begin : g_pipe
        logic [PE_LAT-1:0]            r_tag;
        logic [PE_LAT-1:0][POS_W-1:0] r_tpos;
        logic                         w_pend;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_tag  <= '0;
                r_tpos <= '0;
            end else begin
                r_tag[0]  <= r_step;
                r_tpos[0] <= r_step_pos;
                for (int i = 1; i < int'(PE_LAT); i++) begin
                    r_tag[i]  <= r_tag[i-1];
                    r_tpos[i] <= r_tpos[i-1];
                end
                if (abort) r_tag <= '0;
            end
        end

        // The last stage is consumed on the exit edge, so only earlier stages hold DRAIN
        always_comb begin
            w_pend = r_step;
            for (int i = 0; i < int'(PE_LAT) - 1; i++) w_pend = w_pend | r_tag[i];
        end

        assign w_tag_out   = r_tag[PE_LAT-1];
        assign w_tag_pos   = r_tpos[PE_LAT-1];
        assign w_pipe_busy = w_pend;
    end

    assign in_ready      = (r_state == S_RUN);
    assign busy          = (r_state != S_IDLE);
    assign str_to_router = r_win;
    assign ALU_to_router = r_alu;
    assign en_to_router  = r_en;
    assign match_valid   = r_mvalid;
    assign match_vec     = r_mvec;
    assign match_pos     = r_mpos;
    assign match_cnt     = r_mcnt;
    assign done          = r_done;

endmodule

// File: tb/tb_nfa_stream_ctrl.sv
// Directed bench for nfa_stream_ctrl: one instance with PE_LAT=1, one with PE_LAT=3,
// both driven by the same stimulus and fed by small router models.
module tb_nfa_stream_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned N  = 16;
    localparam int unsigned PW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [N-1:0]  cfg_alu = '0;
    logic [N-1:0]  cfg_mask = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_char = '0;
    logic          in_last = 1'b0;

    logic            rdy1, mv1, busy1, done1;
    logic [N*DW-1:0] str1;
    logic [N-1:0]    alu1, en1, vec1;
    logic [N-1:0]    res1 = '0;
    logic [PW-1:0]   pos1, cnt1;

    logic            rdy3, mv3, busy3, done3;
    logic [N*DW-1:0] str3;
    logic [N-1:0]    alu3, en3, vec3;
    logic [N-1:0]    res3 = '0;
    logic [N-1:0]    p0 = '0;
    logic [N-1:0]    p1 = '0;
    logic [PW-1:0]   pos3, cnt3;

    int res_mode = 0;
    int checks = 0;
    int errors = 0;
    int en_pulses = 0;
    int done_pulses = 0;
    int mv_pulses = 0;
    int done3_pulses = 0;
    int mv3_pulses = 0;
    logic [N-1:0] last_en = '0;

    nfa_stream_ctrl #(.DWIDTH(DW), .num(N), .PE_LAT(1), .POS_W(PW)) dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_alu(cfg_alu), .cfg_mask(cfg_mask),
        .start(start), .abort(abort), .in_valid(in_valid), .in_ready(rdy1), .in_char(in_char),
        .in_last(in_last), .str_to_router(str1), .ALU_to_router(alu1), .en_to_router(en1),
        .result_from_router(res1), .match_valid(mv1), .match_vec(vec1), .match_pos(pos1),
        .match_cnt(cnt1), .busy(busy1), .done(done1)
    );

    nfa_stream_ctrl #(.DWIDTH(DW), .num(N), .PE_LAT(3), .POS_W(PW)) dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_alu(cfg_alu), .cfg_mask(cfg_mask),
        .start(start), .abort(abort), .in_valid(in_valid), .in_ready(rdy3), .in_char(in_char),
        .in_last(in_last), .str_to_router(str3), .ALU_to_router(alu3), .en_to_router(en3),
        .result_from_router(res3), .match_valid(mv3), .match_vec(vec3), .match_pos(pos3),
        .match_cnt(cnt3), .busy(busy3), .done(done3)
    );

    always #5 clk = ~clk;

    // Router model: mode 0 never matches, 1 flags bit 3 when slot 15 holds 'A', 2 flags every step
    function automatic logic [N-1:0] router_model(input int mode, input logic [N-1:0] en,
                                                  input logic [N*DW-1:0] win);
        logic [DW-1:0] s15;
        s15 = win[N*DW-1 -: DW];
        if (en == '0)                      return '0;
        if (mode == 1 && s15 == 8'h41)     return 16'h0008;
        if (mode == 2)                     return 16'h0008;
        return '0;
    endfunction

    always @(posedge clk) res1 <= router_model(res_mode, en1, str1);

    always @(posedge clk) begin
        p0   <= router_model(res_mode, en3, str3);
        p1   <= p0;
        res3 <= p1;
    end

    always @(negedge clk) begin
        if (en1 != '0) begin
            en_pulses <= en_pulses + 1;
            last_en   <= en1;
        end
        if (done1 === 1'b1) done_pulses  <= done_pulses + 1;
        if (mv1 === 1'b1)   mv_pulses    <= mv_pulses + 1;
        if (done3 === 1'b1) done3_pulses <= done3_pulses + 1;
        if (mv3 === 1'b1)   mv3_pulses   <= mv3_pulses + 1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [DW-1:0] c, input logic last);
        in_valid = 1'b1;
        in_char  = c;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done1 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 128'(done1), 128'(1));
        repeat (6) tick();
    endtask

    initial begin
        logic [N*DW-1:0] exp_win;
        int e0, d0, m0, m3, d3;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", 128'(rdy1), 128'(0));
        chk("rst_busy",  128'(busy1), 128'(0));
        chk("rst_done",  128'(done1), 128'(0));
        chk("rst_en",    128'(en1), 128'(0));
        chk("rst_mv",    128'(mv1), 128'(0));
        chk("rst_vec",   128'(vec1), 128'(0));
        chk("rst_cnt",   128'(cnt1), 128'(0));
        chk("rst_str",   128'(str1), 128'(0));
        chk("rst_busy3", 128'(busy3), 128'(0));
        rst_n = 1'b1;
        tick();

        cfg_we = 1'b1; cfg_alu = 16'hA5A5; cfg_mask = 16'hFFFF;
        tick();
        cfg_we = 1'b0;
        chk("cfg_alu", 128'(alu1), 128'(16'hA5A5));

        // 20 chars, result tied low: five steps, no matches
        res_mode = 0;
        e0 = en_pulses; d0 = done_pulses;
        run_start();
        chk("run_ready", 128'(rdy1), 128'(1));
        chk("run_busy",  128'(busy1), 128'(1));
        for (int i = 0; i < 20; i++) feed(DW'(i), i == 19);
        wait_done("t20_done");
        chk("t20_en_pulses", 128'(en_pulses - e0), 128'(5));
        chk("t20_done_once", 128'(done_pulses - d0), 128'(1));
        chk("t20_en_val", 128'(last_en), 128'(16'hFFFF));
        chk("t20_cnt", 128'(cnt1), 128'(0));
        for (int i = 0; i < int'(N); i++) exp_win[i*DW +: DW] = DW'(i + 4);
        chk("t20_window", 128'(str1), 128'(exp_win));

        // 15 spaces then 'A': single match at position 16, checked cycle by cycle
        res_mode = 1;
        m0 = mv_pulses;
        run_start();
        for (int i = 0; i < 15; i++) feed(8'h20, 1'b0);
        feed(8'h41, 1'b1);
        chk("m_en", 128'(en1), 128'(16'hFFFF));
        tick();
        chk("m_mv_early", 128'(mv1), 128'(0));
        tick();
        chk("m_mv",   128'(mv1), 128'(1));
        chk("m_vec",  128'(vec1), 128'(16'h0008));
        chk("m_pos",  128'(pos1), 128'(16));
        chk("m_cnt",  128'(cnt1), 128'(1));
        chk("m_done", 128'(done1), 128'(1));
        chk("m_idle", 128'(busy1), 128'(0));
        repeat (6) tick();
        chk("m_mv_once", 128'(mv_pulses - m0), 128'(1));

        // Short stream: never fills, one DRAIN cycle
        e0 = en_pulses;
        run_start();
        for (int i = 0; i < 10; i++) feed(8'h41, i == 9);
        chk("s_drain_busy", 128'(busy1), 128'(1));
        chk("s_drain_done", 128'(done1), 128'(0));
        tick();
        chk("s_done",     128'(done1), 128'(1));
        chk("s_idle",     128'(busy1), 128'(0));
        chk("s_cnt",      128'(cnt1), 128'(0));
        chk("s_pos_hold", 128'(pos1), 128'(16));
        chk("s_vec_hold", 128'(vec1), 128'(16'h0008));
        chk("s_no_en",    128'(en_pulses - e0), 128'(0));
        repeat (6) tick();

        // Config write during RUN is ignored; in IDLE it takes effect
        res_mode = 0;
        run_start();
        cfg_we = 1'b1; cfg_mask = 16'h0000;
        tick();
        cfg_we = 1'b0;
        for (int i = 0; i < 16; i++) feed(DW'(i), i == 15);
        chk("cfg_run_en", 128'(en1), 128'(16'hFFFF));
        wait_done("cfg_run_done");
        cfg_we = 1'b1; cfg_mask = 16'h0000;
        tick();
        cfg_we = 1'b0;
        e0 = en_pulses;
        run_start();
        for (int i = 0; i < 16; i++) feed(DW'(i), i == 15);
        chk("cfg_idle_en", 128'(en1), 128'(0));
        wait_done("cfg_idle_done");
        chk("cfg_idle_pulses", 128'(en_pulses - e0), 128'(0));
        cfg_we = 1'b1; cfg_mask = 16'hFFFF;
        tick();
        cfg_we = 1'b0;

        // Abort two cycles after a step on the PE_LAT=3 instance
        res_mode = 2;
        m3 = mv3_pulses; d3 = done3_pulses;
        run_start();
        for (int i = 0; i < 16; i++) feed(DW'(i), 1'b0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy3",  128'(busy3), 128'(0));
        chk("ab_ready3", 128'(rdy3), 128'(0));
        chk("ab_busy1",  128'(busy1), 128'(0));
        repeat (8) tick();
        chk("ab_no_mv3",   128'(mv3_pulses - m3), 128'(0));
        chk("ab_no_done3", 128'(done3_pulses - d3), 128'(0));
        chk("ab_cnt3",     128'(cnt3), 128'(0));
        chk("ab_alu_kept", 128'(alu3), 128'(16'hA5A5));

        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("ab_start_busy", 128'(busy1), 128'(0));

        // Reset mid-RUN with in_valid held high
        res_mode = 0;
        run_start();
        for (int i = 0; i < 5; i++) feed(8'h33, 1'b0);
        in_valid = 1'b1; in_char = 8'h55;
        rst_n = 1'b0;
        tick();
        chk("mr_ready", 128'(rdy1), 128'(0));
        chk("mr_busy",  128'(busy1), 128'(0));
        chk("mr_str",   128'(str1), 128'(0));
        chk("mr_alu",   128'(alu1), 128'(0));
        chk("mr_vec",   128'(vec1), 128'(0));
        chk("mr_pos",   128'(pos1), 128'(0));
        chk("mr_en",    128'(en1), 128'(0));
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
